// File: rtl/ct_vfpu_pipe6_pkg.sv
// Shared widths, pipe-select bit positions and writeback payload types for the
// VFALU pipe6 datapath writeback.
package ct_vfpu_pipe6_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned PREG_W = 7;
  localparam int unsigned VREG_W = 7;
  localparam int unsigned EREG_W = 5;

  localparam int unsigned SEL_W    = 3;
  localparam int unsigned SEL_FSPU = 0;
  localparam int unsigned SEL_FADD = 1;
  localparam int unsigned SEL_RSV  = 2;

  typedef struct packed {
    logic [PREG_W-1:0] preg;
    logic [DATA_W-1:0] data;
  } gpr_wb_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [EREG_W-1:0] fflags;
  } vreg_wb_t;

endpackage

// File: rtl/ct_vfpu_dp_pipe6_stage.sv
// One valid+tag pipeline slice; the valid clears on flush and the tag only
// loads alongside a valid, otherwise it holds.
module ct_vfpu_dp_pipe6_stage #(
  parameter int unsigned TAG_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             vld_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             vld_o,
  output logic [TAG_W-1:0] tag_o
);

  logic             vld_d, vld_q;
  logic [TAG_W-1:0] tag_d, tag_q;

  always_comb begin
    vld_d = vld_i & ~flush_i;
    tag_d = tag_q;
    if (vld_d) begin
      tag_d = tag_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  assign vld_o = vld_q;
  assign tag_o = tag_q;

endmodule

// File: rtl/ct_vfpu_dp_pipe6_wb.sv
// Pipe6 datapath consumer: issues the ex1 pipe select, tracks FP destination
// tags to ex4 writeback and returns mfvr data as an ex2 GPR writeback.
module ct_vfpu_dp_pipe6_wb
  import ct_vfpu_pipe6_pkg::*;
(
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              rtu_yy_xx_flush,
  input  logic              idu_vfpu_ex1_inst_vld,
  input  logic [SEL_W-1:0]  idu_vfpu_ex1_func_sel,
  input  logic              idu_vfpu_ex1_mfvr,
  input  logic [PREG_W-1:0] idu_vfpu_ex1_dst_preg,
  input  logic [VREG_W-1:0] idu_vfpu_ex1_dst_vreg,
  input  logic [DATA_W-1:0] pipex_dp_ex1_vfalu_mfvr_data,
  input  logic [DATA_W-1:0] pipex_dp_ex3_vfalu_freg_data,
  input  logic [EREG_W-1:0] pipex_dp_ex3_vfalu_ereg_data,
  input  logic              vfalu_dp_ex3_result_vld,
  output logic [SEL_W-1:0]  dp_vfalu_ex1_pipex_sel,
  output logic              vfpu_rtu_ex2_gpr_wb_vld,
  output logic [PREG_W-1:0] vfpu_rtu_ex2_gpr_wb_preg,
  output logic [DATA_W-1:0] vfpu_rtu_ex2_gpr_wb_data,
  output logic              vfpu_rtu_ex4_vreg_wb_vld,
  output logic [VREG_W-1:0] vfpu_rtu_ex4_vreg_wb_vreg,
  output logic [DATA_W-1:0] vfpu_rtu_ex4_vreg_wb_data,
  output logic [EREG_W-1:0] vfpu_rtu_ex4_fflags,
  output logic              vfpu_dp_pipe6_err
);

  logic              acc_c, fp_iss_c, ex4_load_c, unused_rsv_c;
  logic              ex2_vld, ex3_vld;
  logic [VREG_W-1:0] ex2_vreg, ex3_vreg;
  logic              gpr_vld_d, gpr_vld_q;
  gpr_wb_t           gpr_d, gpr_q;
  vreg_wb_t          vwb_d, vwb_q;
  logic              err_d, err_q;

  // Pipe select is combinational so the VFALU sees it in the issue cycle.
  always_comb begin
    acc_c                            = idu_vfpu_ex1_inst_vld & ~rtu_yy_xx_flush;
    fp_iss_c                         = acc_c & ~idu_vfpu_ex1_mfvr;
    dp_vfalu_ex1_pipex_sel           = '0;
    dp_vfalu_ex1_pipex_sel[SEL_FADD] = idu_vfpu_ex1_func_sel[SEL_FADD] & acc_c;
    dp_vfalu_ex1_pipex_sel[SEL_FSPU] = idu_vfpu_ex1_func_sel[SEL_FSPU] & acc_c;
    unused_rsv_c                     = idu_vfpu_ex1_func_sel[SEL_RSV];
  end

  ct_vfpu_dp_pipe6_stage #(.TAG_W(VREG_W)) u_ex2 (
    .clk(forever_cpuclk), .rst_n(cpurst_b), .flush_i(rtu_yy_xx_flush),
    .vld_i(fp_iss_c), .tag_i(idu_vfpu_ex1_dst_vreg),
    .vld_o(ex2_vld), .tag_o(ex2_vreg)
  );

  ct_vfpu_dp_pipe6_stage #(.TAG_W(VREG_W)) u_ex3 (
    .clk(forever_cpuclk), .rst_n(cpurst_b), .flush_i(rtu_yy_xx_flush),
    .vld_i(ex2_vld), .tag_i(ex2_vreg),
    .vld_o(ex3_vld), .tag_o(ex3_vreg)
  );

  // A missing ex3 result drops the writeback here rather than stalling.
  ct_vfpu_dp_pipe6_stage #(.TAG_W(VREG_W)) u_ex4 (
    .clk(forever_cpuclk), .rst_n(cpurst_b), .flush_i(rtu_yy_xx_flush),
    .vld_i(ex3_vld & vfalu_dp_ex3_result_vld), .tag_i(ex3_vreg),
    .vld_o(vfpu_rtu_ex4_vreg_wb_vld), .tag_o(vfpu_rtu_ex4_vreg_wb_vreg)
  );

  always_comb begin
    ex4_load_c = ex3_vld & vfalu_dp_ex3_result_vld & ~rtu_yy_xx_flush;
    gpr_vld_d  = acc_c & idu_vfpu_ex1_mfvr;
    gpr_d      = gpr_q;
    vwb_d      = vwb_q;
    if (gpr_vld_d) begin
      gpr_d.preg = idu_vfpu_ex1_dst_preg;
      gpr_d.data = pipex_dp_ex1_vfalu_mfvr_data;
    end
    if (ex4_load_c) begin
      vwb_d.data   = pipex_dp_ex3_vfalu_freg_data;
      vwb_d.fflags = pipex_dp_ex3_vfalu_ereg_data;
    end
    err_d = err_q
          | (ex3_vld & ~vfalu_dp_ex3_result_vld)
          | (~ex3_vld & vfalu_dp_ex3_result_vld & ~rtu_yy_xx_flush);
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      gpr_vld_q <= 1'b0;
      gpr_q     <= '0;
      vwb_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      gpr_vld_q <= gpr_vld_d;
      gpr_q     <= gpr_d;
      vwb_q     <= vwb_d;
      err_q     <= err_d;
    end
  end

  assign vfpu_rtu_ex2_gpr_wb_vld   = gpr_vld_q;
  assign vfpu_rtu_ex2_gpr_wb_preg  = gpr_q.preg;
  assign vfpu_rtu_ex2_gpr_wb_data  = gpr_q.data;
  assign vfpu_rtu_ex4_vreg_wb_data = vwb_q.data;
  assign vfpu_rtu_ex4_fflags       = vwb_q.fflags;
  assign vfpu_dp_pipe6_err         = err_q;

endmodule

// File: tb/tb_ct_vfpu_dp_pipe6_wb.sv
// Directed bench for the pipe6 writeback block with hand-computed expectations.
module tb_ct_vfpu_dp_pipe6_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        inst_vld;
  logic [2:0]  func_sel;
  logic        mfvr;
  logic [6:0]  dst_preg;
  logic [6:0]  dst_vreg;
  logic [63:0] mfvr_data;
  logic [63:0] freg_data;
  logic [4:0]  ereg_data;
  logic        result_vld;
  logic [2:0]  pipex_sel;
  logic        gpr_vld;
  logic [6:0]  gpr_preg;
  logic [63:0] gpr_data;
  logic        vwb_vld;
  logic [6:0]  vwb_vreg;
  logic [63:0] vwb_data;
  logic [4:0]  fflags;
  logic        err;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ct_vfpu_dp_pipe6_wb dut (
    .forever_cpuclk               (clk),
    .cpurst_b                     (rst_n),
    .rtu_yy_xx_flush              (flush),
    .idu_vfpu_ex1_inst_vld        (inst_vld),
    .idu_vfpu_ex1_func_sel        (func_sel),
    .idu_vfpu_ex1_mfvr            (mfvr),
    .idu_vfpu_ex1_dst_preg        (dst_preg),
    .idu_vfpu_ex1_dst_vreg        (dst_vreg),
    .pipex_dp_ex1_vfalu_mfvr_data (mfvr_data),
    .pipex_dp_ex3_vfalu_freg_data (freg_data),
    .pipex_dp_ex3_vfalu_ereg_data (ereg_data),
    .vfalu_dp_ex3_result_vld      (result_vld),
    .dp_vfalu_ex1_pipex_sel       (pipex_sel),
    .vfpu_rtu_ex2_gpr_wb_vld      (gpr_vld),
    .vfpu_rtu_ex2_gpr_wb_preg     (gpr_preg),
    .vfpu_rtu_ex2_gpr_wb_data     (gpr_data),
    .vfpu_rtu_ex4_vreg_wb_vld     (vwb_vld),
    .vfpu_rtu_ex4_vreg_wb_vreg    (vwb_vreg),
    .vfpu_rtu_ex4_vreg_wb_data    (vwb_data),
    .vfpu_rtu_ex4_fflags          (fflags),
    .vfpu_dp_pipe6_err            (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; inst_vld = 0; func_sel = 3'b000; mfvr = 0;
    dst_preg = '0; dst_vreg = '0; mfvr_data = '0;
    result_vld = 0; freg_data = '0; ereg_data = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gpr_vld"},  64'(gpr_vld),  64'd0);
    chk({tag, "_gpr_preg"}, 64'(gpr_preg), 64'd0);
    chk({tag, "_gpr_data"}, gpr_data,      64'd0);
    chk({tag, "_vwb_vld"},  64'(vwb_vld),  64'd0);
    chk({tag, "_vwb_vreg"}, 64'(vwb_vreg), 64'd0);
    chk({tag, "_vwb_data"}, vwb_data,      64'd0);
    chk({tag, "_fflags"},   64'(fflags),   64'd0);
    chk({tag, "_err"},      64'(err),      64'd0);
    chk({tag, "_sel"},      64'(pipex_sel), 64'd0);
  endtask

  initial begin
    // Reset state
    idle();
    rst_n = 0;
    step(); step();
    chk_all_zero("rst");
    rst_n = 1;
    step();

    // FP op: issue T, result at T+2, writeback at T+3
    inst_vld = 1; func_sel = 3'b010; dst_vreg = 7'd12;
    #1 chk("fp_sel", 64'(pipex_sel), 64'd2);
    step(); idle();
    chk("fp_t1_vld", 64'(vwb_vld), 64'd0);
    step();
    result_vld = 1; freg_data = 64'h3FF0_0000_0000_0000; ereg_data = 5'b00001;
    step(); idle();
    chk("fp_vld",    64'(vwb_vld),  64'd1);
    chk("fp_vreg",   64'(vwb_vreg), 64'd12);
    chk("fp_data",   vwb_data,      64'h3FF0_0000_0000_0000);
    chk("fp_fflags", 64'(fflags),   64'd1);
    chk("fp_err",    64'(err),      64'd0);
    chk("fp_gpr",    64'(gpr_vld),  64'd0);
    step();
    chk("fp_vld_drop",  64'(vwb_vld), 64'd0);
    chk("fp_data_hold", vwb_data,     64'h3FF0_0000_0000_0000);

    // mfvr: writeback one cycle after issue, no FP writeback
    inst_vld = 1; mfvr = 1; func_sel = 3'b001; dst_preg = 7'd40;
    mfvr_data = 64'h0000_0000_DEAD_BEEF;
    #1 chk("mfvr_sel", 64'(pipex_sel), 64'd1);
    step(); idle();
    chk("mfvr_vld",  64'(gpr_vld),  64'd1);
    chk("mfvr_preg", 64'(gpr_preg), 64'd40);
    chk("mfvr_data", gpr_data,      64'h0000_0000_DEAD_BEEF);
    step();
    chk("mfvr_vld_drop",  64'(gpr_vld), 64'd0);
    chk("mfvr_data_hold", gpr_data,     64'h0000_0000_DEAD_BEEF);
    step(); step();
    chk("mfvr_no_vwb", 64'(vwb_vld), 64'd0);
    chk("mfvr_err",    64'(err),     64'd0);

    // Flush: FP at T and T+1, flush at T+2 with a result and a fresh issue
    inst_vld = 1; func_sel = 3'b010; dst_vreg = 7'd5;
    step();
    dst_vreg = 7'd6;
    step();
    flush = 1; dst_vreg = 7'd7; result_vld = 1;
    freg_data = 64'h1111; ereg_data = 5'd3;
    #1 chk("fl_sel", 64'(pipex_sel), 64'd0);
    chk("fl_vis_vdata", vwb_data, 64'h3FF0_0000_0000_0000);
    chk("fl_vis_gdata", gpr_data, 64'h0000_0000_DEAD_BEEF);
    step(); idle();
    chk("fl_t3_vld", 64'(vwb_vld), 64'd0);
    chk("fl_t3_data", vwb_data, 64'h3FF0_0000_0000_0000);
    step();
    chk("fl_t4_vld", 64'(vwb_vld), 64'd0);
    step();
    chk("fl_t5_vld", 64'(vwb_vld), 64'd0);
    chk("fl_err",    64'(err),     64'd0);

    // Back-to-back FP vregs 1..4 with an mfvr at cycle 4 (mixed traffic)
    for (int i = 0; i < 7; i++) begin
      idle();
      if (i < 4) begin
        inst_vld = 1; func_sel = 3'b010; dst_vreg = 7'(i + 1);
      end else if (i == 4) begin
        inst_vld = 1; mfvr = 1; func_sel = 3'b011; dst_preg = 7'd9;
        mfvr_data = 64'h55;
      end
      if (i >= 2 && i < 6) begin
        result_vld = 1; freg_data = 64'(i - 1); ereg_data = 5'(i + 8);
      end
      if (i == 4) begin
        #1 chk("mix_sel", 64'(pipex_sel), 64'd3);
      end
      step();
      if (i >= 2 && i < 6) begin
        chk($sformatf("b2b_vld%0d", i),  64'(vwb_vld),  64'd1);
        chk($sformatf("b2b_vreg%0d", i), 64'(vwb_vreg), 64'(i - 1));
        chk($sformatf("b2b_data%0d", i), vwb_data,      64'(i - 1));
        chk($sformatf("b2b_ff%0d", i),   64'(fflags),   64'(i + 8));
      end else begin
        chk($sformatf("b2b_idle%0d", i), 64'(vwb_vld), 64'd0);
      end
      if (i == 4) begin
        chk("mix_gpr_vld",  64'(gpr_vld),  64'd1);
        chk("mix_gpr_preg", 64'(gpr_preg), 64'd9);
        chk("mix_gpr_data", gpr_data,      64'h55);
      end
    end
    idle();
    chk("b2b_err", 64'(err), 64'd0);

    // Missing result at ex3: writeback dropped, error sticky
    inst_vld = 1; func_sel = 3'b010; dst_vreg = 7'd7;
    step(); idle();
    step(); step();
    chk("miss_vld", 64'(vwb_vld), 64'd0);
    chk("miss_err", 64'(err),     64'd1);
    step(); step();
    chk("miss_err_held", 64'(err), 64'd1);

    // Orphan result after a reset clears the error
    rst_n = 0;
    #1 chk("rst_err_clr", 64'(err), 64'd0);
    step();
    rst_n = 1;
    step();
    result_vld = 1; freg_data = 64'h99;
    step(); idle();
    chk("orph_err", 64'(err),     64'd1);
    chk("orph_vld", 64'(vwb_vld), 64'd0);
    step();

    // Reset mid-stream: outputs clear asynchronously, issued op never writes back
    inst_vld = 1; func_sel = 3'b010; dst_vreg = 7'd9;
    step(); idle();
    rst_n = 0;
    #1 chk_all_zero("midrst");
    step();
    rst_n = 1;
    step();
    chk("midrst_t3_vld", 64'(vwb_vld), 64'd0);
    chk("midrst_t3_err", 64'(err),     64'd0);
    step();
    chk("midrst_t4_vld", 64'(vwb_vld), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
